jk_cmd_driver: RTL and testbench

Command-driven stimulus stage that sits directly upstream of the `jk` flip-flop and produces its `j`/`k` inputs. It accepts 2-bit commands (hold, clear, set, toggle) through a valid/ready handshake into a small FIFO, and applies each command to the flip-flop as a one-cycle J/K pulse. It then checks the flip-flop's `q` against a predicted value and reports a sticky mismatch flag and a count of completed commands.

---
 rtl/jk_cmd_driver.sv | 145 ++++++++++++++
 tb/tb_jk_cmd_driver.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_driver.sv
// Command-driven J/K stimulus stage: queues hold/clear/set/toggle commands, pulses
// j/k for one cycle per command, predicts the flip-flop state and checks q against it.
module jk_cmd_driver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  output logic             cmd_ready,
  input  logic             q_fb,
  output logic             j,
  output logic             k,
  output logic             exp_q,
  output logic             mismatch,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  logic [1:0]       fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [1:0]       state_q, state_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             exp_q_q, exp_q_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             full, empty, push, pop;
  logic [1:0]       head;

  // Next flip-flop state from the J/K pair that was driven during APPLY.
  function automatic logic jk_next(input logic q, input logic jv, input logic kv);
    logic r;
    case ({jv, kv})
      2'b01:   r = 1'b0;
      2'b10:   r = 1'b1;
      2'b11:   r = ~q;
      default: r = q;
    endcase
    return r;
  endfunction

  assign full      = (occ_q == OCC_W'(DEPTH));
  assign empty     = (occ_q == '0);
  assign cmd_ready = reset & ~full;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = ~empty & ((state_q == S_IDLE) | (state_q == S_CHECK));
  assign head      = fifo_q[rd_ptr_q];

  assign j        = j_q;
  assign k        = k_q;
  assign exp_q    = exp_q_q;
  assign mismatch = mis_q;
  assign done_cnt = cnt_q;
  assign busy     = (state_q != S_IDLE) | ~empty;

  // Command storage is data only; the pointers and occupancy decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= cmd;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    occ_d    = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    j_d     = 1'b0;
    k_d     = 1'b0;
    exp_q_d = exp_q_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          j_d     = head[1];
          k_d     = head[0];
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        exp_q_d = jk_next(exp_q_q, j_q, k_q);
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // The flip-flop sampled j/k at the APPLY exit edge, so q_fb is settled here.
        mis_d = mis_q | (q_fb != exp_q_q);
        cnt_d = cnt_q + CNT_W'(1);
        if (pop) begin
          j_d     = head[1];
          k_d     = head[0];
          state_d = S_APPLY;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      state_q  <= S_IDLE;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      exp_q_q  <= 1'b0;
      mis_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      state_q  <= state_d;
      j_q      <= j_d;
      k_q      <= k_d;
      exp_q_q  <= exp_q_d;
      mis_q    <= mis_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Directed bench for jk_cmd_driver with a behavioural JK flip-flop closing the loop.
module tb_jk_cmd_driver;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd = 2'b00;
  logic             cmd_ready;
  logic             q_fb;
  logic             j, k, exp_q, mismatch, busy;
  logic [CNT_W-1:0] done_cnt;

  logic ff_q = 1'b0;
  logic force_lo = 1'b0;
  int   checks = 0;
  int   failures = 0;

  jk_cmd_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_ready(cmd_ready), .q_fb(q_fb), .j(j), .k(k), .exp_q(exp_q),
    .mismatch(mismatch), .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  // Driven flip-flop, reset together with the driver.
  always @(posedge clk) begin
    if (!reset) ff_q <= 1'b0;
    else begin
      case ({j, k})
        2'b01: ff_q <= 1'b0;
        2'b10: ff_q <= 1'b1;
        2'b11: ff_q <= ~ff_q;
        default: ;
      endcase
    end
  end
  assign q_fb = force_lo ? 1'b0 : ff_q;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    cmd_valid = 1'b0;
    tick();
    checks++;
    if ({j, k, exp_q, mismatch} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=0000", {j, k, exp_q, mismatch});
    end
    checks++;
    if (done_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_done got=%0d exp=0", done_cnt);
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_low got=%b exp=0", cmd_ready);
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_low2 got=%b exp=0", cmd_ready);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL reset_release got=%b exp=10", {cmd_ready, busy});
    end
  endtask

  task automatic test_single_set;
    cmd = 2'b10;
    cmd_valid = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_ready got=%b exp=1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({j, k, busy} !== 3'b001) begin
      failures++;
      $display("FAIL single_e0 got=%b exp=001", {j, k, busy});
    end
    tick();
    checks++;
    if ({j, k, exp_q} !== 3'b100) begin
      failures++;
      $display("FAIL single_pulse got=%b exp=100", {j, k, exp_q});
    end
    tick();
    checks++;
    if ({j, k, exp_q} !== 3'b001 || done_cnt !== 8'd0) begin
      failures++;
      $display("FAIL single_e2 got=%b/%0d exp=001/0", {j, k, exp_q}, done_cnt);
    end
    tick();
    checks++;
    if (done_cnt !== 8'd1 || {mismatch, busy} !== 2'b00) begin
      failures++;
      $display("FAIL single_done got=%0d/%b exp=1/00", done_cnt, {mismatch, busy});
    end
  endtask

  task automatic test_sequence;
    logic [1:0] seq [5];
    logic [1:0] ejk [12];
    logic       eq  [12];
    logic [7:0] edc [12];
    seq = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b00};
    ejk = '{2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    eq  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    edc = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4, 8'd5, 8'd5, 8'd6};
    for (int e = 0; e < 12; e++) begin
      cmd_valid = (e < 5);
      if (e < 5) begin
        cmd = seq[e];
        checks++;
        if (cmd_ready !== 1'b1) begin
          failures++;
          $display("FAIL seq_ready e=%0d got=%b exp=1", e, cmd_ready);
        end
      end
      tick();
      cmd_valid = 1'b0;
      checks++;
      if ({j, k} !== ejk[e] || exp_q !== eq[e] || done_cnt !== edc[e]) begin
        failures++;
        $display("FAIL seq_edge e=%0d got=%b/%b/%0d exp=%b/%b/%0d",
                 e, {j, k}, exp_q, done_cnt, ejk[e], eq[e], edc[e]);
      end
    end
    checks++;
    if ({mismatch, busy} !== 2'b00) begin
      failures++;
      $display("FAIL seq_end got=%b exp=00", {mismatch, busy});
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] cmds [8];
    int idx, cyc;
    logic rdy, saw_low;
    cmds = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
    idx = 0;
    cyc = 0;
    saw_low = 1'b0;
    while (idx < 8 && cyc < 100) begin
      cmd_valid = 1'b1;
      cmd = cmds[idx];
      rdy = cmd_ready;
      if (!rdy) saw_low = 1'b1;
      tick();
      if (rdy) idx++;
      cyc++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (idx !== 8) begin
      failures++;
      $display("FAIL b2b_accepted got=%0d exp=8", idx);
    end
    checks++;
    if (saw_low !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready_drop got=%b exp=1", saw_low);
    end
    while (busy && cyc < 200) begin
      tick();
      cyc++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got=%b exp=0", busy);
    end
    checks++;
    if (done_cnt !== 8'd14 || exp_q !== 1'b1 || mismatch !== 1'b0) begin
      failures++;
      $display("FAIL b2b_result got=%0d/%b/%b exp=14/1/0", done_cnt, exp_q, mismatch);
    end
  endtask

  task automatic test_mismatch;
    logic [1:0] good [3];
    good = '{2'b11, 2'b11, 2'b10};
    force_lo = 1'b1;
    cmd = 2'b10;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    checks++;
    if ({mismatch, exp_q} !== 2'b01) begin
      failures++;
      $display("FAIL mis_before got=%b exp=01", {mismatch, exp_q});
    end
    tick();
    checks++;
    if (mismatch !== 1'b1 || done_cnt !== 8'd15) begin
      failures++;
      $display("FAIL mis_set got=%b/%0d exp=1/15", mismatch, done_cnt);
    end
    force_lo = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cmd = good[n];
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if (mismatch !== 1'b1) begin
        failures++;
        $display("FAIL mis_sticky n=%0d got=%b exp=1", n, mismatch);
      end
    end
    checks++;
    if (done_cnt !== 8'd18 || exp_q !== 1'b1) begin
      failures++;
      $display("FAIL mis_count got=%0d/%b exp=18/1", done_cnt, exp_q);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    for (int e = 0; e < 4; e++) begin
      cmd = 2'b11;
      cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    checks++;
    if ({j, k} !== 2'b11) begin
      failures++;
      $display("FAIL rmid_apply2 got=%b exp=11", {j, k});
    end
    reset = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL rmid_ready got=%b exp=0", cmd_ready);
    end
    tick();
    checks++;
    if ({j, k, exp_q, mismatch, busy} !== 5'b00000 || done_cnt !== 8'd0) begin
      failures++;
      $display("FAIL rmid_edge got=%b/%0d exp=00000/0", {j, k, exp_q, mismatch, busy}, done_cnt);
    end
    reset = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (j || k || busy) pulses++;
    end
    checks++;
    if (pulses !== 0 || done_cnt !== 8'd0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rmid_after got=%0d/%0d/%b exp=0/0/1", pulses, done_cnt, cmd_ready);
    end
  endtask

  task automatic test_wrap;
    int idx, cyc;
    logic rdy, saw_wrap, exp_changed;
    logic [7:0] prev;
    cmd = 2'b10;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (done_cnt !== 8'd1 || exp_q !== 1'b1) begin
      failures++;
      $display("FAIL wrap_pre got=%0d/%b exp=1/1", done_cnt, exp_q);
    end
    idx = 0;
    cyc = 0;
    saw_wrap = 1'b0;
    exp_changed = 1'b0;
    prev = done_cnt;
    while ((idx < 256 || busy) && cyc < 2000) begin
      cmd_valid = (idx < 256);
      cmd = 2'b00;
      rdy = cmd_ready;
      tick();
      if (rdy && idx < 256) idx++;
      if (prev == 8'd255 && done_cnt == 8'd0) saw_wrap = 1'b1;
      if (exp_q !== 1'b1) exp_changed = 1'b1;
      prev = done_cnt;
      cyc++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (idx !== 256 || busy !== 1'b0) begin
      failures++;
      $display("FAIL wrap_run got=%0d/%b exp=256/0", idx, busy);
    end
    checks++;
    if (saw_wrap !== 1'b1) begin
      failures++;
      $display("FAIL wrap_seen got=%b exp=1", saw_wrap);
    end
    checks++;
    if (exp_changed !== 1'b0 || done_cnt !== 8'd1 || mismatch !== 1'b0) begin
      failures++;
      $display("FAIL wrap_end got=%b/%0d/%b exp=0/1/0", exp_changed, done_cnt, mismatch);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_set();
    test_sequence();
    test_back_to_back();
    test_mismatch();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
